// File: rtl/mouse_pos_cdc_tx.sv
// Source side of the mouse-position CDC: launches position samples on a held bus with a
// toggle req/ack handshake, keeping one latest-wins pending sample while a transfer is in flight.
module mouse_pos_cdc_tx #(
    parameter int DW          = 12,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    xpos_in,
    input  logic [DW-1:0]    ypos_in,
    input  logic             pos_valid,
    output logic [DW-1:0]    xpos_hold,
    output logic [DW-1:0]    ypos_hold,
    output logic             req_tgl,
    input  logic             ack_tgl_async,
    output logic             busy,
    output logic             overrun,
    output logic [CNT_W-1:0] overrun_cnt
);

    typedef enum logic {IDLE, WAIT_ACK} state_t;

    state_t             state_q, state_d;
    logic [DW-1:0]      xhold_q, xhold_d, yhold_q, yhold_d;
    logic [DW-1:0]      pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic               pend_v_q, pend_v_d;
    logic               req_q, req_d;
    logic               busy_q, busy_d;
    logic               ovr_q, ovr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] ack_sync_q;

    logic ack_s;
    logic done;
    logic launch;
    logic use_pend;

    // Ack synchroniser chain; stage 0 is the only flop that sees the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) ack_sync_q[0] <= 1'b0;
        else     ack_sync_q[0] <= ack_tgl_async;
    end

    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
        always_ff @(posedge clk) begin
            if (rst) ack_sync_q[gi] <= 1'b0;
            else     ack_sync_q[gi] <= ack_sync_q[gi-1];
        end
    end

    assign ack_s = ack_sync_q[SYNC_STAGES-1];
    assign done  = (ack_s == req_q);

    always_comb begin
        state_d  = state_q;
        xhold_d  = xhold_q;
        yhold_d  = yhold_q;
        pend_x_d = pend_x_q;
        pend_y_d = pend_y_q;
        pend_v_d = pend_v_q;
        req_d    = req_q;
        busy_d   = busy_q;
        ovr_d    = 1'b0;
        cnt_d    = cnt_q;
        launch   = 1'b0;
        use_pend = 1'b0;

        if (state_q == IDLE || done) begin
            // A fresh strobe always beats the pending sample, which is then simply dropped.
            if (pos_valid) begin
                launch   = 1'b1;
                pend_v_d = 1'b0;
            end else if (pend_v_q) begin
                launch   = 1'b1;
                use_pend = 1'b1;
                pend_v_d = 1'b0;
            end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        end else if (pos_valid) begin
            pend_x_d = xpos_in;
            pend_y_d = ypos_in;
            pend_v_d = 1'b1;
            if (pend_v_q) begin
                ovr_d = 1'b1;
                if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
            end
        end

        if (launch) begin
            xhold_d = use_pend ? pend_x_q : xpos_in;
            yhold_d = use_pend ? pend_y_q : ypos_in;
            req_d   = ~req_q;
            state_d = WAIT_ACK;
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            xhold_q  <= '0;
            yhold_q  <= '0;
            pend_x_q <= '0;
            pend_y_q <= '0;
            pend_v_q <= 1'b0;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            xhold_q  <= xhold_d;
            yhold_q  <= yhold_d;
            pend_x_q <= pend_x_d;
            pend_y_q <= pend_y_d;
            pend_v_q <= pend_v_d;
            req_q    <= req_d;
            busy_q   <= busy_d;
            ovr_q    <= ovr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign xpos_hold   = xhold_q;
    assign ypos_hold   = yhold_q;
    assign req_tgl     = req_q;
    assign busy        = busy_q;
    assign overrun     = ovr_q;
    assign overrun_cnt = cnt_q;

endmodule

// File: tb/tb_mouse_pos_cdc_tx.sv
// Bench for mouse_pos_cdc_tx: directed handshake scenarios checked against a transfer-level
// model every cycle, plus literal expectations for the key scenarios.
module tb_mouse_pos_cdc_tx;

    localparam int DW = 12;
    localparam int SS = 2;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] xpos_in, ypos_in;
    logic          pos_valid;
    logic [DW-1:0] xpos_hold, ypos_hold;
    logic          req_tgl;
    logic          ack_tgl_async;
    logic          busy;
    logic          overrun;
    logic [CW-1:0] overrun_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    mouse_pos_cdc_tx #(.DW(DW), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .xpos_in(xpos_in), .ypos_in(ypos_in), .pos_valid(pos_valid),
        .xpos_hold(xpos_hold), .ypos_hold(ypos_hold), .req_tgl(req_tgl),
        .ack_tgl_async(ack_tgl_async), .busy(busy),
        .overrun(overrun), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    // Transfer-level model: a sample is in flight until the receiver's ack, seen SS edges
    // late, matches the request level; newest sample always wins.
    bit      m_inflight, m_req, m_pend, m_ovr;
    int      m_x, m_y, m_px, m_py, m_cnt;
    bit      ack_hist[$];

    always @(posedge clk) begin
        bit seen_ack;
        if (rst) begin
            m_inflight = 0; m_req = 0; m_pend = 0; m_ovr = 0;
            m_x = 0; m_y = 0; m_px = 0; m_py = 0; m_cnt = 0;
            ack_hist.delete();
            for (int i = 0; i < SS; i++) ack_hist.push_back(1'b0);
        end else begin
            seen_ack = ack_hist.pop_front();
            ack_hist.push_back(ack_tgl_async);
            m_ovr = 0;
            if (!m_inflight || seen_ack == m_req) begin
                if (pos_valid) begin
                    m_x = xpos_in; m_y = ypos_in; m_req = !m_req; m_inflight = 1; m_pend = 0;
                end else if (m_pend) begin
                    m_x = m_px; m_y = m_py; m_req = !m_req; m_inflight = 1; m_pend = 0;
                end else begin
                    m_inflight = 0;
                end
            end else if (pos_valid) begin
                if (m_pend) begin
                    m_ovr = 1;
                    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                end
                m_px = xpos_in; m_py = ypos_in; m_pend = 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // One clock: wait for the falling edge, then check every output against the model.
    task automatic cyc();
        @(negedge clk);
        chk("model_xhold", 32'(xpos_hold), 32'(m_x));
        chk("model_yhold", 32'(ypos_hold), 32'(m_y));
        chk("model_req", 32'(req_tgl), 32'(m_req));
        chk("model_busy", 32'(busy), 32'(m_inflight));
        chk("model_ovr", 32'(overrun), 32'(m_ovr));
        chk("model_cnt", 32'(overrun_cnt), 32'(m_cnt));
    endtask

    task automatic strobe(input int x, input int y);
        pos_valid = 1'b1; xpos_in = DW'(x); ypos_in = DW'(y);
        cyc();
        pos_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (busy !== 1'b0 && k < 20) begin cyc(); k++; end
        chk(nm, 32'(busy), 32'd0);
    endtask

    task automatic wait_hold(input int x, input string nm);
        int k = 0;
        while (xpos_hold !== DW'(x) && k < 20) begin cyc(); k++; end
        chk(nm, 32'(xpos_hold), 32'(x));
    endtask

    initial begin
        int k;
        rst = 1'b1; pos_valid = 1'b0; xpos_in = '0; ypos_in = '0; ack_tgl_async = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        chk("reset_busy", 32'(busy), 32'd0);

        // Single transfer and ack latency
        strobe(12'h123, 12'h0AB);
        chk("single_x", 32'(xpos_hold), 32'h123);
        chk("single_y", 32'(ypos_hold), 32'h0AB);
        chk("single_req", 32'(req_tgl), 32'd1);
        chk("single_busy", 32'(busy), 32'd1);
        ack_tgl_async = 1'b1;
        k = 0;
        while (busy === 1'b1 && k < 20) begin cyc(); k++; end
        chk("ack_latency", 32'(k), 32'(SS + 1));
        $display("txn single: hold=%h/%h ack latency %0d", xpos_hold, ypos_hold, k);

        // Pending sample launched back-to-back on ack
        strobe(12'h050, 12'h060);
        strobe(12'h200, 12'h100);
        chk("pend_hold_kept", 32'(xpos_hold), 32'h050);
        ack_tgl_async = 1'b0;
        wait_hold(12'h200, "pend_launch_x");
        chk("pend_launch_y", 32'(ypos_hold), 32'h100);
        chk("pend_req", 32'(req_tgl), 32'd1);
        chk("pend_busy", 32'(busy), 32'd1);
        $display("txn pending: hold=%h/%h req=%b", xpos_hold, ypos_hold, req_tgl);
        ack_tgl_async = 1'b1;
        wait_idle("pend_idle");

        // Overrun: second strobe in one wait replaces the first
        strobe(12'h001, 12'h001);
        strobe(12'h010, 12'h011);
        chk("ovr_first_none", 32'(overrun), 32'd0);
        strobe(12'h020, 12'h021);
        chk("ovr_pulse", 32'(overrun), 32'd1);
        chk("ovr_cnt", 32'(overrun_cnt), 32'd1);
        cyc();
        chk("ovr_pulse_end", 32'(overrun), 32'd0);
        ack_tgl_async = 1'b0;
        wait_hold(12'h020, "ovr_latest");
        $display("txn overrun: cnt=%0d hold=%h", overrun_cnt, xpos_hold);
        ack_tgl_async = 1'b1;
        wait_idle("ovr_idle");

        // Stability while in flight
        strobe(12'h0AA, 12'h0BB);
        for (int i = 0; i < 10; i++) begin
            xpos_in = DW'($urandom); ypos_in = DW'($urandom);
            cyc();
            chk("stable_x", 32'(xpos_hold), 32'h0AA);
            chk("stable_req", 32'(req_tgl), 32'd0);
        end
        $display("txn stability: hold=%h held for 10 cycles", xpos_hold);
        ack_tgl_async = 1'b0;
        wait_idle("stable_idle");

        // Collision: strobe lands on the done cycle with a sample pending
        strobe(12'h111, 12'h111);
        ack_tgl_async = 1'b1;
        strobe(12'h222, 12'h222);
        cyc();
        strobe(12'h333, 12'h334);
        chk("coll_x", 32'(xpos_hold), 32'h333);
        chk("coll_no_ovr", 32'(overrun), 32'd0);
        chk("coll_cnt", 32'(overrun_cnt), 32'd1);
        ack_tgl_async = 1'b0;
        wait_idle("coll_idle");
        chk("coll_pend_dropped", 32'(xpos_hold), 32'h333);
        $display("txn collision: hold=%h cnt=%0d", xpos_hold, overrun_cnt);

        // Saturation: 300 more overruns
        strobe(12'h001, 12'h001);
        for (int i = 0; i < 301; i++) strobe(i, i);
        chk("sat_cnt", 32'(overrun_cnt), 32'hFF);
        chk("sat_pulse", 32'(overrun), 32'd1);
        $display("txn saturation: cnt=0x%h", overrun_cnt);

        // Reset in the middle of a transfer with a sample pending
        rst = 1'b1; ack_tgl_async = 1'b0;
        repeat (3) cyc();
        chk("mrst_x", 32'(xpos_hold), 32'd0);
        chk("mrst_y", 32'(ypos_hold), 32'd0);
        chk("mrst_req", 32'(req_tgl), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_ovr", 32'(overrun), 32'd0);
        chk("mrst_cnt", 32'(overrun_cnt), 32'd0);
        rst = 1'b0;
        cyc();
        chk("mrst_no_relaunch", 32'(busy), 32'd0);
        strobe(12'hABC, 12'h456);
        chk("post_rst_req", 32'(req_tgl), 32'd1);
        ack_tgl_async = 1'b1;
        wait_idle("post_rst_idle");
        $display("txn post-reset: hold=%h/%h", xpos_hold, ypos_hold);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
